// File: rtl/blast_mem_pkg.sv
// Shared types and widths for the DDR read-channel arbiter.
package blast_mem_pkg;

  localparam int DDR_ADDR_W = 32;
  localparam int DDR_DATA_W = 512;
  localparam int BEAT_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority selector: first set request bit after last_i, wrapping.
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] last_i,
  output logic            valid_o,
  output logic [ID_W-1:0] idx_o
);

  logic [ID_W-1:0] cand;

  // Scan from farthest to nearest so the nearest requester after last_i wins.
  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    cand    = '0;
    for (int k = N; k >= 1; k--) begin
      cand = ID_W'((int'(last_i) + k) % N);
      if (req_i[cand]) begin
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/ddr_rd_arbiter.sv
// Round-robin arbiter sharing one DDR read channel between NUM_REQ engines.
// One transaction in flight at a time; beats and completion are routed
// back to the owner one cycle after the DDR presents them. A watchdog ends
// transactions that go silent for TIMEOUT cycles.
module ddr_rd_arbiter
  import blast_mem_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = DDR_ADDR_W,
  parameter int DATA_WIDTH = DDR_DATA_W,
  parameter int TIMEOUT    = 1024,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_rd,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_grant,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [NUM_REQ-1:0]            rsp_done,
  output logic                          ddr_rd,
  output logic [ADDR_WIDTH-1:0]         readAdd,
  input  logic                          ddr_rd_valid,
  input  logic [DATA_WIDTH-1:0]         ddr_rd_data,
  input  logic                          ddr_rd_done,
  output logic                          busy,
  output logic [ID_W-1:0]               owner,
  output logic [BEAT_CNT_W-1:0]         beat_count,
  output logic                          timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  state_e                  state_q, state_d;
  logic [ID_W-1:0]         owner_q, owner_d;
  logic [ID_W-1:0]         last_q, last_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [BEAT_CNT_W-1:0]   beat_q, beat_d;
  logic [WD_W-1:0]         wd_q, wd_d;
  logic                    ddr_rd_q, ddr_rd_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0]      rsp_done_q, rsp_done_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                    tmo_q, tmo_d;
  logic                    busy_q, busy_d;

  logic                    pick_valid;
  logic [ID_W-1:0]         pick_idx;
  logic [ADDR_WIDTH-1:0]   addr_arr [NUM_REQ];

  // Unpack the flat address bus into one slice per engine.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
    assign addr_arr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
  end

  rr_pick #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req_i   (req_rd),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // Next-state and registered-output computation for the IDLE/ISSUE/WAIT FSM.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    addr_d      = addr_q;
    beat_d      = beat_q;
    wd_d        = wd_q;
    ddr_rd_d    = 1'b0;
    grant_d     = '0;
    rsp_valid_d = '0;
    rsp_done_d  = '0;
    rsp_data_d  = rsp_data_q;
    tmo_d       = 1'b0;
    case (state_q)
      IDLE: begin
        // DDR traffic here belongs to nobody and is dropped.
        if (pick_valid) begin
          owner_d  = pick_idx;
          addr_d   = addr_arr[pick_idx];
          ddr_rd_d = 1'b1;
          grant_d  = ONE << pick_idx;
          beat_d   = '0;
          wd_d     = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (ddr_rd_valid) begin
          rsp_valid_d = ONE << owner_q;
          rsp_data_d  = ddr_rd_data;
          beat_d      = (beat_q == {BEAT_CNT_W{1'b1}}) ? beat_q : beat_q + 1'b1;
          wd_d        = '0;
        end
        if (ddr_rd_done) begin
          rsp_done_d = ONE << owner_q;
          last_d     = owner_q;
          state_d    = IDLE;
        end else if (!ddr_rd_valid) begin
          if (wd_q == WD_W'(TIMEOUT - 1)) begin
            tmo_d      = 1'b1;
            rsp_done_d = ONE << owner_q;
            last_d     = owner_q;
            wd_d       = '0;
            state_d    = IDLE;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; last owner resets to the top index so engine 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      last_q      <= ID_W'(NUM_REQ - 1);
      addr_q      <= '0;
      beat_q      <= '0;
      wd_q        <= '0;
      ddr_rd_q    <= 1'b0;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      rsp_done_q  <= '0;
      rsp_data_q  <= '0;
      tmo_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      beat_q      <= beat_d;
      wd_q        <= wd_d;
      ddr_rd_q    <= ddr_rd_d;
      grant_q     <= grant_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_done_q  <= rsp_done_d;
      rsp_data_q  <= rsp_data_d;
      tmo_q       <= tmo_d;
      busy_q      <= busy_d;
    end
  end

  assign req_grant   = grant_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_done    = rsp_done_q;
  assign ddr_rd      = ddr_rd_q;
  assign readAdd     = addr_q;
  assign busy        = busy_q;
  assign owner       = owner_q;
  assign beat_count  = beat_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Scoreboard bench: stimulus pushes expected grants, beats and completions;
// a negedge monitor pops and compares whenever the arbiter presents them.
module tb_ddr_rd_arbiter;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int TMO = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_rd = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    req_grant, rsp_valid, rsp_done;
  logic [DW-1:0]   rsp_data;
  logic            ddr_rd;
  logic [AW-1:0]   readAdd;
  logic            ddr_rd_valid = 1'b0;
  logic [DW-1:0]   ddr_rd_data = '0;
  logic            ddr_rd_done = 1'b0;
  logic            busy;
  logic [1:0]      owner;
  logic [15:0]     beat_count;
  logic            timeout_err;

  ddr_rd_arbiter #(
    .NUM_REQ    (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_rd       (req_rd),
    .req_addr     (req_addr),
    .req_grant    (req_grant),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_done     (rsp_done),
    .ddr_rd       (ddr_rd),
    .readAdd      (readAdd),
    .ddr_rd_valid (ddr_rd_valid),
    .ddr_rd_data  (ddr_rd_data),
    .ddr_rd_done  (ddr_rd_done),
    .busy         (busy),
    .owner        (owner),
    .beat_count   (beat_count),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { int at; int id; logic [AW-1:0] addr; } grant_t;
  typedef struct { int at; int id; logic [DW-1:0] data; int cnt; bit busy; } beat_t;
  typedef struct { int at; int id; bit tmo; int cnt; logic [AW-1:0] addr; } done_t;

  grant_t gq[$];
  beat_t  bq[$];
  done_t  dq[$];

  // Reference state: which engines are requesting, their addresses, last winner.
  bit            pend [N];
  logic [AW-1:0] paddr [N];
  int            m_last;
  int            m_cnt;
  logic [AW-1:0] cur_addr;
  int            last_issue = -100;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic int rr_expect();
    for (int k = 1; k <= N; k++) begin
      if (pend[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req();
    for (int i = 0; i < N; i++) begin
      req_rd[i] = pend[i];
      req_addr[i*AW +: AW] = paddr[i];
    end
  endtask

  task automatic quiet();
    ddr_rd_valid = 1'b0;
    ddr_rd_done  = 1'b0;
    ddr_rd_data  = {$urandom, $urandom};
  endtask

  task automatic stray_or_quiet(input bit strays);
    quiet();
    if (strays) begin
      ddr_rd_valid = 1'($urandom_range(0, 1));
      ddr_rd_done  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic churn();
    if ($urandom_range(0, 7) == 0) begin
      int i;
      i = $urandom_range(0, N - 1);
      if (!pend[i]) begin
        pend[i]  = 1'b1;
        paddr[i] = $urandom;
      end else begin
        pend[i] = 1'b0;
      end
    end
    drive_req();
  endtask

  // Called in an IDLE cycle; returns in the first WAIT cycle.
  task automatic issue(input bit drop, input bit strays, output int own);
    drive_req();
    own = rr_expect();
    cur_addr = paddr[own];
    gq.push_back('{cyc + 1, own, paddr[own]});
    stray_or_quiet(strays);
    tick();
    if (drop) pend[own] = 1'b0;
    if (strays) churn(); else drive_req();
    stray_or_quiet(strays);
    tick();
    quiet();
  endtask

  // mode 0: end with done, 1: go silent until watchdog, 2: stop after beats.
  task automatic serve(input int own, input int nb, input int mode, input bit directed, input bit chn);
    for (int b = 0; b < nb; b++) begin
      bit last;
      logic [DW-1:0] d;
      int gap;
      gap = directed ? 0 : $urandom_range(0, 3);
      repeat (gap) begin
        if (chn) churn();
        tick();
        quiet();
      end
      d = directed ? DW'((b + 1) * 17) : {$urandom, $urandom};
      last = (mode == 0) && (b == nb - 1);
      ddr_rd_valid = 1'b1;
      ddr_rd_data  = d;
      ddr_rd_done  = last;
      bq.push_back('{cyc + 1, own, d, b + 1, !last});
      if (last) dq.push_back('{cyc + 1, own, 1'b0, nb, cur_addr});
      if (chn) churn();
      tick();
      quiet();
    end
    if (mode == 0 && nb == 0) begin
      repeat (directed ? 0 : $urandom_range(0, 3)) tick();
      ddr_rd_done = 1'b1;
      dq.push_back('{cyc + 1, own, 1'b0, 0, cur_addr});
      tick();
      quiet();
    end
    if (mode == 1) begin
      dq.push_back('{cyc + TMO, own, 1'b1, nb, cur_addr});
      repeat (TMO) begin
        if (chn) churn();
        tick();
      end
    end
    if (mode != 2) begin
      m_last = own;
      m_cnt  = nb;
    end
  endtask

  grant_t g;
  beat_t  bt;
  done_t  dn;

  // Monitor: compare every presented output against the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (ddr_rd || req_grant != '0) begin
        if (gq.size() == 0) chk("grant_unexpected", {ddr_rd, req_grant}, 0);
        else begin
          g = gq.pop_front();
          chk("grant_cycle", cyc, g.at);
          chk("grant_onehot", req_grant, 1 << g.id);
          chk("ddr_rd", ddr_rd, 1);
          chk("readAdd", readAdd, g.addr);
          chk("owner", owner, g.id);
          chk("busy_issue", busy, 1);
          chk("issue_spacing", (cyc - last_issue) >= 3, 1);
          last_issue = cyc;
        end
      end else if (gq.size() != 0 && gq[0].at <= cyc) begin
        chk("grant_missing", ddr_rd, 1);
        void'(gq.pop_front());
      end

      if (rsp_valid != '0) begin
        if (bq.size() == 0) chk("beat_unexpected", rsp_valid, 0);
        else begin
          bt = bq.pop_front();
          chk("beat_cycle", cyc, bt.at);
          chk("rsp_valid_onehot", rsp_valid, 1 << bt.id);
          chk("rsp_data", rsp_data, bt.data);
          chk("beat_count", beat_count, bt.cnt);
          chk("busy_beat", busy, bt.busy);
        end
      end else if (bq.size() != 0 && bq[0].at <= cyc) begin
        chk("beat_missing", rsp_valid, 1 << bq[0].id);
        void'(bq.pop_front());
      end

      if (rsp_done != '0) begin
        if (dq.size() == 0) chk("done_unexpected", rsp_done, 0);
        else begin
          dn = dq.pop_front();
          chk("done_cycle", cyc, dn.at);
          chk("rsp_done_onehot", rsp_done, 1 << dn.id);
          chk("timeout_err", timeout_err, dn.tmo);
          chk("done_beat_count", beat_count, dn.cnt);
          chk("readAdd_hold", readAdd, dn.addr);
          chk("busy_done", busy, 0);
          $display("txn: owner=%0d beats=%0d timeout=%0d cycle=%0d", dn.id, dn.cnt, dn.tmo, cyc);
        end
      end else if (dq.size() != 0 && dq[0].at <= cyc) begin
        chk("done_missing", rsp_done, 1 << dq[0].id);
        void'(dq.pop_front());
      end

      if (timeout_err && rsp_done == '0) chk("timeout_orphan", timeout_err, 0);
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"}, req_grant, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_done"}, rsp_done, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_ddr_rd"}, ddr_rd, 0);
    chk({tag, "_readAdd"}, readAdd, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_owner"}, owner, 0);
    chk({tag, "_beat_count"}, beat_count, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin
    int own;
    for (int i = 0; i < N; i++) begin
      pend[i]  = 1'b0;
      paddr[i] = $urandom;
    end
    m_last = N - 1;
    m_cnt  = 0;

    // Reset state.
    tick();
    tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Single request, three directed beats, done on the last.
    pend[0]  = 1'b1;
    paddr[0] = 32'h100;
    issue(1'b1, 1'b0, own);
    serve(own, 3, 0, 1'b1, 1'b0);

    // All engines request continuously, one beat each.
    for (int i = 0; i < N; i++) begin
      pend[i]  = 1'b1;
      paddr[i] = $urandom;
    end
    repeat (5) begin
      issue(1'b0, 1'b0, own);
      serve(own, 1, 0, 1'b0, 1'b0);
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;

    // Make engine 2 the last owner, then contend 0 and 2 (wrap past 3).
    pend[2] = 1'b1;
    issue(1'b1, 1'b0, own);
    serve(own, 1, 0, 1'b0, 1'b0);
    pend[0] = 1'b1;
    pend[2] = 1'b1;
    issue(1'b1, 1'b0, own);
    serve(own, 1, 0, 1'b0, 1'b0);
    issue(1'b1, 1'b0, own);
    serve(own, 2, 0, 1'b0, 1'b0);

    // Stray DDR traffic while idle.
    drive_req();
    ddr_rd_valid = 1'b1;
    ddr_rd_data  = DW'(8'hFF);
    ddr_rd_done  = 1'b1;
    tick();
    quiet();
    chk("stray_rsp_valid", rsp_valid, 0);
    chk("stray_beat_count", beat_count, m_cnt);
    tick();
    chk("stray_busy", busy, 0);

    // Watchdog: engine 1, no DDR response at all.
    pend[1] = 1'b1;
    issue(1'b1, 1'b0, own);
    serve(own, 0, 1, 1'b0, 1'b0);
    tick();
    chk("busy_after_timeout", busy, 0);

    // Reset in the middle of WAIT after two beats.
    pend[3] = 1'b1;
    issue(1'b1, 1'b0, own);
    serve(own, 2, 2, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    gq.delete();
    bq.delete();
    dq.delete();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive_req();
    tick();
    rst = 1'b0;
    m_last = N - 1;
    ddr_rd_done  = 1'b1;
    ddr_rd_valid = 1'b1;
    tick();
    quiet();
    tick();
    chk("post_reset_beat_count", beat_count, 0);
    chk("post_reset_busy", busy, 0);
    pend[0]  = 1'b1;
    pend[3]  = 1'b1;
    paddr[0] = $urandom;
    paddr[3] = $urandom;
    issue(1'b1, 1'b0, own);
    serve(own, 1, 0, 1'b0, 1'b0);

    // Randomized traffic.
    repeat (60) begin
      int any;
      any = 0;
      repeat ($urandom_range(0, 2)) begin
        req_rd = '0;
        stray_or_quiet(1'b1);
        tick();
      end
      for (int i = 0; i < N; i++) any += int'(pend[i]);
      if (any == 0) begin
        int i;
        i = $urandom_range(0, N - 1);
        pend[i]  = 1'b1;
        paddr[i] = $urandom;
      end
      issue($urandom_range(0, 3) != 0, 1'b1, own);
      serve(own, $urandom_range(0, 4), ($urandom_range(0, 9) == 0) ? 1 : 0, 1'b0, 1'b1);
    end

    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive_req();
    quiet();
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ddr_rd_arbiter.md
Name: ddr_rd_arbiter

Overview:
- Shares the single DDR read channel (ddr_rd / readAdd / ddr_rd_valid / ddr_rd_data / ddr_rd_done) between NUM_REQ memory-interface engines, one per query lane.
- Grants one read transaction at a time using round-robin priority.
- Issues the DDR read and routes returned beats and completion to the owning engine.
- A watchdog ends any transaction that never receives ddr_rd_done.

Parameters:
NUM_REQ, 4, number of requesting engines (2..8)
ADDR_WIDTH, 32, DDR address width
DATA_WIDTH, 512, DDR read data width
TIMEOUT, 1024, idle cycles without a beat or done before abort
ID_W, $clog2(NUM_REQ), owner index width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
req_rd  in  NUM_REQ  per-engine read request level; held until granted
req_addr  in  NUM_REQ*ADDR_WIDTH  per-engine address; slice i belongs to engine i; stable while req_rd[i]=1
req_grant  out  NUM_REQ  one-cycle one-hot acceptance pulse
rsp_valid  out  NUM_REQ  one-hot beat-valid to the owner
rsp_data  out  DATA_WIDTH  registered beat data, broadcast to all engines
rsp_done  out  NUM_REQ  one-hot one-cycle transaction-end pulse
ddr_rd  out  1  one-cycle DDR read command
readAdd  out  ADDR_WIDTH  DDR read address, valid with ddr_rd
ddr_rd_valid  in  1  DDR beat valid
ddr_rd_data  in  DATA_WIDTH  DDR beat data
ddr_rd_done  in  1  DDR transaction complete
busy  out  1  high in ISSUE and WAIT
owner  out  ID_W  index of the current or most recent owner
beat_count  out  16  beats of the current or most recent transaction; saturates at 0xFFFF
timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset: all outputs 0. State IDLE. last_owner = NUM_REQ-1, so engine 0 wins first. Watchdog = 0.
- States:
  - IDLE: if any req_rd bit is set, pick the first set bit starting at last_owner+1 (mod NUM_REQ). Latch the index and its address, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE (exactly 1 cycle): ddr_rd=1, readAdd=latched address, req_grant[owner]=1, beat_count cleared to 0, watchdog cleared. Go to WAIT.
  - WAIT:
    - Each ddr_rd_valid: next cycle rsp_valid[owner]=1 and rsp_data=ddr_rd_data. beat_count increments. Watchdog clears.
    - ddr_rd_done: next cycle rsp_done[owner]=1, last_owner=owner, go to IDLE.
    - Valid and done in the same cycle: the beat belongs to this transaction. rsp_valid and rsp_done assert together on the next cycle.
    - No valid and no done for TIMEOUT consecutive cycles: next cycle timeout_err=1, rsp_done[owner]=1, last_owner=owner, go to IDLE.
- Latency: request seen in IDLE at cycle t gives grant and ddr_rd at t+1. Responses lag DDR inputs by exactly 1 cycle.
- Minimum spacing: done at cycle t gives IDLE at t+1 and the next ddr_rd at t+2.
- readAdd holds its value after ISSUE until the next ISSUE.
- An engine whose req_rd is still high after its rsp_done is treated as a new request. It waits behind every other active requester.
- ddr_rd_valid or ddr_rd_done seen in IDLE or ISSUE is ignored. No rsp output asserts for it.
- Request bits dropped before grant are simply not considered. A request is never granted on a stale bit.
- rst asserted mid-transaction: everything returns to reset values immediately. Late DDR beats after reset are ignored because the state is IDLE.
- Outputs are registered. The only combinational logic is the arbitration pick inside IDLE.

Decomposition:
- Package blast_mem_pkg:
  - DDR_ADDR_W=32, DDR_DATA_W=512
  - state enum {IDLE, ISSUE, WAIT}
  - BEAT_CNT_W=16
- Sub-module rr_pick: combinational rotate-priority one-hot selector. Inputs are the request vector and last_owner. Outputs are a valid flag and the index.

Test Plan:
1. Single request: req_rd=4'b0001, addr0=0x100 -> cycle+1 ddr_rd=1, readAdd=0x100, req_grant=0001. Three beats 0x11,0x22,0x33 with done on the third -> rsp_valid[0] for 3 cycles, beat_count=3, rsp_done[0] with the last beat.
2. Round-robin: all four request continuously, each transaction 1 beat -> grant order 0,1,2,3,0. ddr_rd pulses spaced at least 3 cycles apart.
3. Contention after owner 2: last_owner=2, req_rd=4'b0101 -> engine 0 granted (wrap past 3), then engine 2.
4. Stray traffic: ddr_rd_valid=1 with data 0xFF pulsed in IDLE -> no rsp_valid, beat_count unchanged.
5. Timeout: TIMEOUT=16, grant engine 1, no DDR response -> after 16 silent cycles, timeout_err=1 and rsp_done[1]=1 in the same cycle. busy=0 on the next cycle.
6. Reset mid-WAIT after 2 beats: rst pulsed -> all outputs 0, beat_count=0. Subsequent ddr_rd_done ignored. Next request goes to engine 0.
